// File: rtl/noc_pkg.sv
// Shared NoC flit definitions: default field widths, field extraction and the
// saturating 8-bit statistics increment used by both sources and sinks.
package noc_pkg;

  localparam int FLIT_SIZE      = 8;
  localparam int FLIT_DEST_BITS = 4;

  typedef logic [FLIT_SIZE-1:0]                flit_t;
  typedef logic [FLIT_DEST_BITS-1:0]           dest_t;
  typedef logic [FLIT_SIZE-FLIT_DEST_BITS-1:0] payload_t;

  function automatic dest_t flit_dest(flit_t flit);
    return flit[FLIT_DEST_BITS-1:0];
  endfunction

  function automatic payload_t flit_payload(flit_t flit);
    return flit[FLIT_SIZE-1:FLIT_DEST_BITS];
  endfunction

  // Statistics stick at 255 rather than wrapping so checkers never see a reset-like drop.
  function automatic logic [7:0] sat_inc8(logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/flit_sink_if.sv
// Sink-side bundle: two-phase req/ack flit channel plus the valid/ready drain port.
interface flit_sink_if #(
  parameter int SIZE             = 8,
  parameter int DESTINATION_BITS = 4
);

  logic                             req;
  logic                             ack;
  logic [SIZE-1:0]                  data;
  logic                             out_valid;
  logic                             out_ready;
  logic [SIZE-DESTINATION_BITS-1:0] out_data;

  modport master (output req, data, out_ready, input ack, out_valid, out_data);
  modport slave  (input req, data, out_ready, output ack, out_valid, out_data);

endinterface

// File: rtl/flit_fifo.sv
// Small payload FIFO with natural-wrap pointers and an extra count bit to tell full from empty.
module flit_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_BITS = $clog2(DEPTH);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_reg;
  logic [PTR_BITS-1:0] rd_ptr_reg;
  logic [PTR_BITS:0]   count_reg;
  logic                push_ok;
  logic                pop_ok;

  assign full    = (count_reg == (PTR_BITS+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_BITS'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_BITS'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (PTR_BITS+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_BITS+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no reset: count gates every read of stale entries.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  assign head_data = mem[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/flit_sink.sv
// Destination endpoint: acknowledges two-phase flits, buffers payloads addressed to ID,
// drops and counts misrouted ones, and drains the buffer over valid/ready.
module flit_sink
  import noc_pkg::*;
#(
  parameter int ID               = 0,
  parameter int SIZE             = FLIT_SIZE,
  parameter int DESTINATION_BITS = FLIT_DEST_BITS,
  parameter int DEPTH            = 4
) (
  input  logic       clk,
  input  logic       reset,
  flit_sink_if.slave chan,
  output logic [7:0] rx_count,
  output logic [7:0] misrouted_count
);

  localparam int PAYLOAD_BITS = SIZE - DESTINATION_BITS;
  localparam logic [DESTINATION_BITS-1:0] ID_DEST = DESTINATION_BITS'(ID);

  logic [DESTINATION_BITS-1:0] dest;
  logic [PAYLOAD_BITS-1:0]     payload;
  logic [PAYLOAD_BITS-1:0]     head_data;
  logic [$clog2(DEPTH):0]      fifo_count;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        pending;
  logic                        match;
  logic                        consume;
  logic                        push;
  logic                        pop;
  logic                        ack_reg;
  logic [7:0]                  rx_count_reg;
  logic [7:0]                  misrouted_count_reg;

  generate
    if (SIZE == FLIT_SIZE && DESTINATION_BITS == FLIT_DEST_BITS) begin : g_pkg_decode
      assign dest    = flit_dest(chan.data);
      assign payload = flit_payload(chan.data);
    end else begin : g_slice_decode
      assign dest    = chan.data[DESTINATION_BITS-1:0];
      assign payload = chan.data[SIZE-1:DESTINATION_BITS];
    end
  endgenerate

  // Full is the registered state, so a pop on this edge only frees room for the next one.
  assign pending = chan.req ^ ack_reg;
  assign match   = (dest == ID_DEST);
  assign consume = pending && (!match || !fifo_full);
  assign push    = consume && match;
  assign pop     = chan.out_ready && !fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_reg             <= 1'b0;
      rx_count_reg        <= 8'd0;
      misrouted_count_reg <= 8'd0;
    end else if (consume) begin
      ack_reg      <= chan.req;
      rx_count_reg <= sat_inc8(rx_count_reg);
      if (!match) misrouted_count_reg <= sat_inc8(misrouted_count_reg);
    end
  end

  flit_fifo #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (payload),
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign chan.ack        = ack_reg;
  assign chan.out_valid  = (fifo_count != '0);
  assign chan.out_data   = head_data;
  assign rx_count        = rx_count_reg;
  assign misrouted_count = misrouted_count_reg;

endmodule

// File: tb/tb_flit_sink.sv
// Directed bench for flit_sink (ID=0, 8-bit flits, 4-bit destination, depth 4).
module tb_flit_sink;

  logic       clk;
  logic       reset;
  logic [7:0] rx_count;
  logic [7:0] misrouted_count;

  int compared   = 0;
  int mismatched = 0;

  flit_sink_if #(.SIZE(8), .DESTINATION_BITS(4)) chan ();

  flit_sink #(
    .ID               (0),
    .SIZE             (8),
    .DESTINATION_BITS (4),
    .DEPTH            (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .chan            (chan),
    .rx_count        (rx_count),
    .misrouted_count (misrouted_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      $error("%s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] flit);
    chan.data = flit;
    chan.req  = ~chan.req;
    step();
    $display("flit 0x%02h: ack=%0d valid=%0d out=0x%0h rx=%0d mis=%0d", flit, chan.ack,
             chan.out_valid, chan.out_data, rx_count, misrouted_count);
  endtask

  // Data must hold still while a flit is pending and unacknowledged.
  logic       prev_pend  = 1'b0;
  logic       prev_ack   = 1'b0;
  logic       prev_reset = 1'b1;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clk) begin
    if (!reset && !prev_reset && (chan.req ^ chan.ack) && prev_pend && chan.ack == prev_ack)
      chk("data_stable", 32'(chan.data), 32'(prev_data));
    prev_pend  <= chan.req ^ chan.ack;
    prev_ack   <= chan.ack;
    prev_reset <= reset;
    prev_data  <= chan.data;
  end

  initial begin
    reset          = 1'b1;
    chan.req       = 1'b0;
    chan.data      = 8'h00;
    chan.out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("rst_ack", 32'(chan.ack), 32'h0);
    chk("rst_valid", 32'(chan.out_valid), 32'h0);
    chk("rst_rx", 32'(rx_count), 32'd0);
    chk("rst_mis", 32'(misrouted_count), 32'd0);

    // 1: single flit, visible one edge after the toggle
    send(8'h40);
    chk("t1_ack", 32'(chan.ack), 32'h1);
    chk("t1_valid", 32'(chan.out_valid), 32'h1);
    chk("t1_data", 32'(chan.out_data), 32'h4);
    chk("t1_rx", 32'(rx_count), 32'd1);
    chk("t1_mis", 32'(misrouted_count), 32'd0);
    chan.out_ready = 1'b1;
    step();
    chan.out_ready = 1'b0;
    chk("t1_drained", 32'(chan.out_valid), 32'h0);

    // 2: fill to depth, fifth flit held until a pop frees room
    send(8'h10); chk("t2_ack1", 32'(chan.ack), 32'h0);
    send(8'h20); chk("t2_ack2", 32'(chan.ack), 32'h1);
    send(8'h30); chk("t2_ack3", 32'(chan.ack), 32'h0);
    send(8'h40); chk("t2_ack4", 32'(chan.ack), 32'h1);
    send(8'h50); chk("t2_hold_a", 32'(chan.ack), 32'h1);
    step();      chk("t2_hold_b", 32'(chan.ack), 32'h1);
    chk("t2_rx_held", 32'(rx_count), 32'd5);
    chan.out_ready = 1'b1;
    step();
    chan.out_ready = 1'b0;
    chk("t2_pop_noack", 32'(chan.ack), 32'h1);
    chk("t2_head", 32'(chan.out_data), 32'h2);
    step();
    chk("t2_ack5", 32'(chan.ack), 32'h0);
    chk("t2_rx", 32'(rx_count), 32'd6);
    chan.out_ready = 1'b1;
    chk("t2_d2", 32'(chan.out_data), 32'h2); step();
    chk("t2_d3", 32'(chan.out_data), 32'h3); step();
    chk("t2_d4", 32'(chan.out_data), 32'h4); step();
    chk("t2_d5", 32'(chan.out_data), 32'h5); step();
    chan.out_ready = 1'b0;
    chk("t2_empty", 32'(chan.out_valid), 32'h0);

    // 3: misrouted flit is acked and dropped
    send(8'h73);
    chk("t3_ack", 32'(chan.ack), 32'h1);
    chk("t3_valid", 32'(chan.out_valid), 32'h0);
    chk("t3_mis", 32'(misrouted_count), 32'd1);
    chk("t3_rx", 32'(rx_count), 32'd7);

    // 4: push and pop on the same edge with two entries buffered
    send(8'h10);
    send(8'h20);
    chan.out_ready = 1'b1;
    send(8'h30);
    chan.out_ready = 1'b0;
    chk("t4_ack", 32'(chan.ack), 32'h0);
    chk("t4_head", 32'(chan.out_data), 32'h2);
    chk("t4_rx", 32'(rx_count), 32'd10);
    chan.out_ready = 1'b1;
    chk("t4_d2", 32'(chan.out_data), 32'h2); step();
    chk("t4_d3", 32'(chan.out_data), 32'h3); step();
    chan.out_ready = 1'b0;
    chk("t4_empty", 32'(chan.out_valid), 32'h0);

    // 5: reset with entries buffered and a request pending
    send(8'h10);
    send(8'h20);
    send(8'h30);
    chk("t5_pre_valid", 32'(chan.out_valid), 32'h1);
    chan.data = 8'h40;
    chan.req  = ~chan.req;
    reset     = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_valid", 32'(chan.out_valid), 32'h0);
    chk("t5_ack", 32'(chan.ack), 32'h0);
    chk("t5_rx", 32'(rx_count), 32'd0);
    chk("t5_mis", 32'(misrouted_count), 32'd0);
    step();
    chk("t5_idle_valid", 32'(chan.out_valid), 32'h0);
    send(8'h60);
    chk("t5_new_ack", 32'(chan.ack), 32'h1);
    chk("t5_new_data", 32'(chan.out_data), 32'h6);
    chk("t5_new_rx", 32'(rx_count), 32'd1);

    // 6: 300 misrouted flits saturate both counters
    reset     = 1'b1;
    chan.req  = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 255; i++) send(8'h01);
    chk("t6_rx_255", 32'(rx_count), 32'd255);
    chk("t6_mis_255", 32'(misrouted_count), 32'd255);
    chk("t6_ack_255", 32'(chan.ack), 32'h1);
    for (int i = 0; i < 45; i++) send(8'h01);
    chk("t6_rx_sat", 32'(rx_count), 32'd255);
    chk("t6_mis_sat", 32'(misrouted_count), 32'd255);
    chk("t6_ack_end", 32'(chan.ack), 32'h0);
    chk("t6_valid", 32'(chan.out_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
